alu_display_driver: RTL and testbench
=====================================

Name: alu_display_driver

Overview:
- Drives six 8-bit seven-segment displays (disp5..disp0) showing the ALU result selected by `op`.
- Inputs are four precomputed 6-bit ALU results: XNOR, shift, add and multiply.
- Sits between the ALU datapath and the board HEX displays.
- Display layout: operation letter, a dash separator, the result in hex, then the result in decimal.

Parameters:
- SEG_BLANK, 8'hFF, pattern for an unlit digit.
- SEG_DASH, 8'hBF, separator pattern (segment g only).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-high reset. The port keeps the codebase name `rst_n`, but it is asserted when 1.
- en  in  1  capture enable; when 0, displays hold their current patterns.
- op  in  2  result select: 00 xnor, 01 shift, 10 add, 11 mult.
- Doutxnor  in  6  XNOR result, unsigned.
- Doutshift  in  6  shift result, unsigned.
- Doutadd  in  6  add result, unsigned.
- Doutmult  in  6  multiply result, unsigned.
- disp0  out  8  decimal ones digit.
- disp1  out  8  decimal tens digit.
- disp2  out  8  hex low nibble.
- disp3  out  8  hex high nibble.
- disp4  out  8  separator.
- disp5  out  8  operation letter.

Behaviour:
- Segment encoding is active-low: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g, bit7=dp. A 0 lights the segment. The dp bit is always 1.
- Digit patterns:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Operation letters on disp5: op 00 'n'=AB, op 01 'S'=92, op 10 'A'=88, op 11 'P'=8C.
- Value select (combinational): val = op 00 Doutxnor, 01 Doutshift, 10 Doutadd, 11 Doutmult.
- Hex fields:
  - disp3 = hex({2'b00, val[5:4]}), range 0..3.
  - disp2 = hex(val[3:0]).
- Decimal fields:
  - tens = val/10, range 0..6; ones = val%10.
  - Implement with a compare/subtract chain; no divider.
  - disp1 = digit(tens), disp0 = digit(ones).
  - A leading-zero tens digit is shown as 0, not blanked.
- disp4 = SEG_DASH whenever not in reset state.
- All six outputs are registers.
  - On a rising clk edge with rst_n=0 and en=1, every disp register loads the pattern for the current op and val.
  - Latency is 1 cycle from input change to display.
- With en=0, all outputs hold their previous values, including across op or input changes.
- Reset: while rst_n=1, all six outputs are SEG_BLANK (8'hFF) immediately, independent of clk.
  - Reset mid-operation blanks the displays at once.
  - After release, outputs stay blank until the first enabled rising edge.
- Simultaneous op and data change: whatever op and data are present at the capturing edge are displayed together. No mixing of old op with new data.
- Boundaries:
  - val=0 shows "n-00 00" (for op 00).
  - val=63 shows hex "3F" and decimal "63".
  - val=9/10 is the decimal carry boundary (tens 0→1).

Decomposition:
- Package alu_disp_pkg: SEG_* constants (digits 0-F, letters n/S/A/P, dash, blank) and op encodings OP_XNOR, OP_SHIFT, OP_ADD, OP_MULT.
- One sub-module: seg7_hex_decoder (4-bit in, 8-bit active-low pattern out). Instantiate it four times for disp3..disp0.
- Top level holds the mux, the binary-to-decimal split, the op-letter lookup and the output registers.

Test Plan:
- Reset: assert rst_n=1 mid-run with clk stopped → all disp = FF immediately. Release, keep en=0, clock 3 edges → still all FF.
- All inputs = 6'b010101 (21); op cycles 00, 01, 10, 11, one enabled edge each → disp4..disp0 = BF, F9, 92, A4, F9 each time. disp5 = AB, 92, 88, 8C respectively.
- Doutadd=63, op=10 → disp5..disp0 = 88, BF, B0, 8E, 82, B0.
- Doutmult=0 then 9 then 10, op=11 → decimal fields 0/0, then 0/9, then 1/0 (disp1/disp0 = C0/C0, C0/90, F9/C0). Hex fields 00, 09, 0A.
- Hold: capture 21 on op=00, then en=0 and change op to 10 and Doutxnor to 5 → outputs unchanged. Re-enable → update exactly 1 edge later.
- Latency check: change Doutshift with op=01 just after an edge → display updates on the next rising edge, not before.

Source files
------------

// File: rtl/alu_disp_pkg.sv
// alu_disp_pkg
// Shared constants for the ALU seven-segment display driver.
//   - Active-low segment patterns (bit0=a .. bit6=g, bit7=dp, dp always off)
//     for hex digits 0-F, operation letters n/S/A/P, dash and blank.
//   - Result-select encodings for the op input.
package alu_disp_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [7:0] SEG_LTR_N = 8'hAB;
    localparam logic [7:0] SEG_LTR_S = 8'h92;
    localparam logic [7:0] SEG_LTR_A = 8'h88;
    localparam logic [7:0] SEG_LTR_P = 8'h8C;

    typedef enum logic [1:0] {
        OP_XNOR  = 2'b00,
        OP_SHIFT = 2'b01,
        OP_ADD   = 2'b10,
        OP_MULT  = 2'b11
    } op_e;

endpackage

// File: rtl/alu_display_driver_seg7_hex_decoder.sv
// seg7_hex_decoder
// Combinational 4-bit to active-low seven-segment pattern decoder.
//   i_nibble : 4-bit value 0..F
//   o_seg    : 8-bit active-low pattern (dp off)
module seg7_hex_decoder
    import alu_disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/alu_display_driver.sv
// alu_display_driver
// Shows the ALU result chosen by op on six registered seven-segment digits:
// disp5 = op letter, disp4 = dash, disp3/disp2 = hex, disp1/disp0 = decimal.
//   clk        : rising-edge clock
//   rst_n      : asynchronous reset, asserted HIGH (name kept for compatibility)
//   en         : capture enable; 0 holds all displays
//   op         : 00 xnor, 01 shift, 10 add, 11 mult
//   Doutxnor, Doutshift, Doutadd, Doutmult : 6-bit unsigned ALU results
//   disp0..disp5 : active-low segment patterns, registered, 1-cycle latency
module alu_display_driver
    import alu_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] op,
    input  logic [5:0] Doutxnor,
    input  logic [5:0] Doutshift,
    input  logic [5:0] Doutadd,
    input  logic [5:0] Doutmult,
    output logic [7:0] disp0,
    output logic [7:0] disp1,
    output logic [7:0] disp2,
    output logic [7:0] disp3,
    output logic [7:0] disp4,
    output logic [7:0] disp5
);

    logic [5:0] w_val;
    logic [2:0] w_tens;
    logic [5:0] w_rem;
    logic [7:0] w_letter;
    logic [7:0] w_seg_hex_hi, w_seg_hex_lo, w_seg_tens, w_seg_ones;

    logic [7:0] r_disp0, r_disp1, r_disp2, r_disp3, r_disp4, r_disp5;

    always_comb begin
        w_val    = Doutxnor;
        w_letter = SEG_LTR_N;
        case (op_e'(op))
            OP_XNOR:  begin w_val = Doutxnor;  w_letter = SEG_LTR_N; end
            OP_SHIFT: begin w_val = Doutshift; w_letter = SEG_LTR_S; end
            OP_ADD:   begin w_val = Doutadd;   w_letter = SEG_LTR_A; end
            OP_MULT:  begin w_val = Doutmult;  w_letter = SEG_LTR_P; end
            default:  begin w_val = Doutxnor;  w_letter = SEG_LTR_N; end
        endcase
    end

    // Binary to tens/ones: six conditional subtract-10 stages cover 0..63.
    always_comb begin
        w_rem  = w_val;
        w_tens = 3'd0;
        for (int unsigned k = 0; k < 6; k++) begin
            if (w_rem >= 6'd10) begin
                w_rem  = w_rem - 6'd10;
                w_tens = w_tens + 3'd1;
            end
        end
    end

    seg7_hex_decoder u_dec_hex_hi (.i_nibble({2'b00, w_val[5:4]}), .o_seg(w_seg_hex_hi));
    seg7_hex_decoder u_dec_hex_lo (.i_nibble(w_val[3:0]),          .o_seg(w_seg_hex_lo));
    seg7_hex_decoder u_dec_tens   (.i_nibble({1'b0, w_tens}),      .o_seg(w_seg_tens));
    seg7_hex_decoder u_dec_ones   (.i_nibble(w_rem[3:0]),          .o_seg(w_seg_ones));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_disp0 <= SEG_BLANK;
            r_disp1 <= SEG_BLANK;
            r_disp2 <= SEG_BLANK;
            r_disp3 <= SEG_BLANK;
            r_disp4 <= SEG_BLANK;
            r_disp5 <= SEG_BLANK;
        end else if (en) begin
            r_disp0 <= w_seg_ones;
            r_disp1 <= w_seg_tens;
            r_disp2 <= w_seg_hex_lo;
            r_disp3 <= w_seg_hex_hi;
            r_disp4 <= SEG_DASH;
            r_disp5 <= w_letter;
        end
    end

    assign disp0 = r_disp0;
    assign disp1 = r_disp1;
    assign disp2 = r_disp2;
    assign disp3 = r_disp3;
    assign disp4 = r_disp4;
    assign disp5 = r_disp5;

endmodule

// File: tb/tb_alu_display_driver.sv
// tb_alu_display_driver
// Directed, self-checking bench for alu_display_driver. Expected display
// words {disp5..disp0} are hand-computed constants.
module tb_alu_display_driver;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic       en;
    logic [1:0] op;
    logic [5:0] Doutxnor, Doutshift, Doutadd, Doutmult;
    logic [7:0] disp0, disp1, disp2, disp3, disp4, disp5;

    int unsigned tests;
    int unsigned fails;

    alu_display_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .op        (op),
        .Doutxnor  (Doutxnor),
        .Doutshift (Doutshift),
        .Doutadd   (Doutadd),
        .Doutmult  (Doutmult),
        .disp0     (disp0),
        .disp1     (disp1),
        .disp2     (disp2),
        .disp3     (disp3),
        .disp4     (disp4),
        .disp5     (disp5)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [47:0] disp_word();
        return {disp5, disp4, disp3, disp2, disp1, disp0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [47:0] got;
        // clock stopped, reset asserted: blank immediately
        clk_run = 1'b0;
        rst_n = 1'b1;
        en = 1'b0;
        #2;
        got = disp_word();
        tests++;
        if (got !== 48'hFFFF_FFFF_FFFF) begin
            fails++;
            $display("FAIL reset_async: got %h want %h", got, 48'hFFFF_FFFF_FFFF);
        end
        rst_n = 1'b0;
        clk_run = 1'b1;
        repeat (3) tick();
        got = disp_word();
        tests++;
        if (got !== 48'hFFFF_FFFF_FFFF) begin
            fails++;
            $display("FAIL reset_release_en0: got %h want %h", got, 48'hFFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_op_cycle();
        logic [47:0] got;
        logic [47:0] exp_tab [4];
        exp_tab[0] = 48'hAB_BF_F9_92_A4_F9;
        exp_tab[1] = 48'h92_BF_F9_92_A4_F9;
        exp_tab[2] = 48'h88_BF_F9_92_A4_F9;
        exp_tab[3] = 48'h8C_BF_F9_92_A4_F9;
        Doutxnor = 6'd21; Doutshift = 6'd21; Doutadd = 6'd21; Doutmult = 6'd21;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = 2'(i);
            tick();
            got = disp_word();
            tests++;
            if (got !== exp_tab[i]) begin
                fails++;
                $display("FAIL op_cycle_%0d: got %h want %h", i, got, exp_tab[i]);
            end
        end
    endtask

    task automatic test_max();
        logic [47:0] got;
        Doutadd = 6'd63;
        op = 2'b10;
        en = 1'b1;
        tick();
        got = disp_word();
        tests++;
        if (got !== 48'h88_BF_B0_8E_82_B0) begin
            fails++;
            $display("FAIL max_63: got %h want %h", got, 48'h88_BF_B0_8E_82_B0);
        end
        // zero on xnor: "n-00 00"
        Doutxnor = 6'd0;
        op = 2'b00;
        tick();
        got = disp_word();
        tests++;
        if (got !== 48'hAB_BF_C0_C0_C0_C0) begin
            fails++;
            $display("FAIL zero_xnor: got %h want %h", got, 48'hAB_BF_C0_C0_C0_C0);
        end
    endtask

    task automatic test_carry();
        logic [47:0] got;
        logic [5:0]  vals    [3];
        logic [47:0] exp_tab [3];
        vals[0] = 6'd0;  exp_tab[0] = 48'h8C_BF_C0_C0_C0_C0;
        vals[1] = 6'd9;  exp_tab[1] = 48'h8C_BF_C0_90_C0_90;
        vals[2] = 6'd10; exp_tab[2] = 48'h8C_BF_C0_88_F9_C0;
        op = 2'b11;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Doutmult = vals[i];
            tick();
            got = disp_word();
            tests++;
            if (got !== exp_tab[i]) begin
                fails++;
                $display("FAIL carry_%0d: got %h want %h", vals[i], got, exp_tab[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [47:0] got;
        Doutxnor = 6'd21;
        op = 2'b00;
        en = 1'b1;
        tick();
        en = 1'b0;
        op = 2'b10;
        Doutxnor = 6'd5;
        Doutadd = 6'd42;
        repeat (2) tick();
        got = disp_word();
        tests++;
        if (got !== 48'hAB_BF_F9_92_A4_F9) begin
            fails++;
            $display("FAIL hold_en0: got %h want %h", got, 48'hAB_BF_F9_92_A4_F9);
        end
        en = 1'b1;
        #1;
        got = disp_word();
        tests++;
        if (got !== 48'hAB_BF_F9_92_A4_F9) begin
            fails++;
            $display("FAIL hold_reenable_pre: got %h want %h", got, 48'hAB_BF_F9_92_A4_F9);
        end
        tick();
        got = disp_word();
        tests++;
        if (got !== 48'h88_BF_A4_88_99_A4) begin
            fails++;
            $display("FAIL hold_reenable_post: got %h want %h", got, 48'h88_BF_A4_88_99_A4);
        end
    endtask

    task automatic test_latency();
        logic [47:0] got;
        op = 2'b01;
        Doutshift = 6'd21;
        en = 1'b1;
        tick();
        Doutshift = 6'd37;
        @(negedge clk);
        #1;
        got = disp_word();
        tests++;
        if (got !== 48'h92_BF_F9_92_A4_F9) begin
            fails++;
            $display("FAIL latency_before: got %h want %h", got, 48'h92_BF_F9_92_A4_F9);
        end
        tick();
        got = disp_word();
        tests++;
        if (got !== 48'h92_BF_A4_92_B0_F8) begin
            fails++;
            $display("FAIL latency_after: got %h want %h", got, 48'h92_BF_A4_92_B0_F8);
        end
    endtask

    task automatic test_simultaneous();
        logic [47:0] got;
        op = 2'b00;
        Doutxnor = 6'd21;
        Doutmult = 6'd9;
        en = 1'b1;
        tick();
        op = 2'b11;
        Doutmult = 6'd63;
        Doutxnor = 6'd0;
        tick();
        got = disp_word();
        tests++;
        if (got !== 48'h8C_BF_B0_8E_82_B0) begin
            fails++;
            $display("FAIL simultaneous: got %h want %h", got, 48'h8C_BF_B0_8E_82_B0);
        end
    endtask

    task automatic test_reset_mid();
        logic [47:0] got;
        @(negedge clk);
        clk_run = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        got = disp_word();
        tests++;
        if (got !== 48'hFFFF_FFFF_FFFF) begin
            fails++;
            $display("FAIL reset_mid: got %h want %h", got, 48'hFFFF_FFFF_FFFF);
        end
        #3;
        rst_n = 1'b0;
        en = 1'b0;
        clk_run = 1'b1;
        repeat (2) tick();
        got = disp_word();
        tests++;
        if (got !== 48'hFFFF_FFFF_FFFF) begin
            fails++;
            $display("FAIL reset_mid_release: got %h want %h", got, 48'hFFFF_FFFF_FFFF);
        end
        en = 1'b1;
        tick();
        got = disp_word();
        tests++;
        if (got !== 48'h8C_BF_B0_8E_82_B0) begin
            fails++;
            $display("FAIL reset_mid_first_capture: got %h want %h", got, 48'h8C_BF_B0_8E_82_B0);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clk_run = 1'b0;
        rst_n = 1'b1;
        en = 1'b0;
        op = 2'b00;
        Doutxnor = '0; Doutshift = '0; Doutadd = '0; Doutmult = '0;
        test_reset();
        test_op_cycle();
        test_max();
        test_carry();
        test_hold();
        test_latency();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
